// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and types for the multi-port register file with scoreboard.
package rf_pkg;

   localparam int RF_XLEN     = 32;
   localparam int RF_NUM_REGS = 32;
   localparam int RF_AW       = $clog2(RF_NUM_REGS);

   typedef logic [RF_AW-1:0]   reg_addr_t;
   typedef logic [RF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits tracking pending writebacks.
// Next-state priority per register: rst > flush > issue > write-clear > hold.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int NUM_WR   = 2,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WR-1:0]    we,
   input  logic [NUM_WR*AW-1:0] wa,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   input  logic                 flush,
   output logic [NUM_REGS-1:0]  busy,
   output logic                 iss_ok
);

   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_nxt_s;
   logic                iss_fire_s;

   // Issue is accepted only when the destination is free and is not register 0
   assign iss_ok     = ~busy_r[iss_rd];
   assign iss_fire_s = iss_valid & iss_ok & (iss_rd != {AW{1'b0}});
   assign busy       = busy_r;

   // Next busy vector: lowest-priority actions applied first so later ones override
   always_comb begin
      busy_nxt_s = busy_r;
      for (int j = 0; j < NUM_WR; j++) begin
         if (we[j]) begin
            busy_nxt_s[wa[j*AW +: AW]] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
      end
      if (iss_fire_s) begin
         busy_nxt_s[iss_rd] = 1'b1;
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
      if (flush) begin
         busy_nxt_s = {NUM_REGS{1'b0}};
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
      // Register 0 can never become busy
      busy_nxt_s[0] = 1'b0;
   end

   // Busy state register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= {NUM_REGS{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

endmodule

// File: rtl/rf_sb.sv
// rf_sb: multi-port integer register file with optional write-to-read bypass
// and an integrated scoreboard for stalling on pending writebacks.
module rf_sb
   import rf_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   rs_addr,
   output logic [NUM_RD*XLEN-1:0] rs_data,
   output logic [NUM_RD-1:0]      rs_ready,
   input  logic [NUM_WR-1:0]      we,
   input  logic [NUM_WR*AW-1:0]   wa,
   input  logic [NUM_WR*XLEN-1:0] wd,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_rd,
   output logic                   iss_ok,
   input  logic                   flush
);

   logic [XLEN-1:0]     regs_r    [NUM_REGS];
   logic [NUM_REGS-1:0] busy_s;
   logic [NUM_WR-1:0]   we_eff_s;
   logic [AW-1:0]       rd_addr_s [NUM_RD];
   logic                bp_hit_s  [NUM_RD];
   logic [XLEN-1:0]     bp_data_s [NUM_RD];

   // Writes to register 0 are dropped before reaching either the array or the scoreboard
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         we_eff_s[j] = we[j] & (wa[j*AW +: AW] != {AW{1'b0}});
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .we        (we_eff_s),
      .wa        (wa),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .flush     (flush),
      .busy      (busy_s),
      .iss_ok    (iss_ok)
   );

   // Data array: ports applied in ascending order so the highest-index port wins on collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_r[k] <= {XLEN{1'b0}};
         end
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (we_eff_s[j]) begin
               regs_r[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Bypass match per read port; the last matching write port overrides earlier ones
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_addr_s[i] = rs_addr[i*AW +: AW];
         bp_hit_s[i]  = 1'b0;
         bp_data_s[i] = {XLEN{1'b0}};
         for (int j = 0; j < NUM_WR; j++) begin
            bp_data_s[i] = (we_eff_s[j] && (wa[j*AW +: AW] == rd_addr_s[i])) ?
                           wd[j*XLEN +: XLEN] : bp_data_s[i];
            bp_hit_s[i]  = bp_hit_s[i] | (we_eff_s[j] & (wa[j*AW +: AW] == rd_addr_s[i]));
         end
         // Forwarding is disabled in the no-bypass build and while reset holds the array cleared
         bp_hit_s[i] = bp_hit_s[i] & (BYPASS != 0) & ~rst;
      end
   end

   // Read mux: register 0, then bypass, then array value with its busy status
   always_comb begin
      rs_data  = {(NUM_RD*XLEN){1'b0}};
      rs_ready = {NUM_RD{1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_addr_s[i] == {AW{1'b0}}) begin
            rs_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
            rs_ready[i]             = 1'b1;
         end else if (bp_hit_s[i]) begin
            rs_data[i*XLEN +: XLEN] = bp_data_s[i];
            rs_ready[i]             = 1'b1;
         end else begin
            rs_data[i*XLEN +: XLEN] = regs_r[rd_addr_s[i]];
            rs_ready[i]             = ~busy_s[rd_addr_s[i]];
         end
      end
   end

endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: directed self-checking bench for rf_sb (bypass and no-bypass builds side by side).
module tb_rf_sb;
   import rf_pkg::*;

   localparam int XL  = 32;
   localparam int NR  = 32;
   localparam int AW  = 5;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] rs_addr;
   logic [NRD*XL-1:0] rs_data, rs_data_nb;
   logic [NRD-1:0]    rs_ready, rs_ready_nb;
   logic [NWR-1:0]    we;
   logic [NWR*AW-1:0] wa;
   logic [NWR*XL-1:0] wd;
   logic              iss_valid;
   logic [AW-1:0]     iss_rd;
   logic              iss_ok, iss_ok_nb;
   logic              flush;

   int tests_run = 0;
   int fails     = 0;

   always #5 clk = ~clk;

   rf_sb #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_ready(rs_ready),
      .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_ok(iss_ok), .flush(flush));

   rf_sb #(.XLEN(XL), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_ready(rs_ready_nb),
      .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
      .iss_ok(iss_ok_nb), .flush(flush));

   task automatic idle();
      we = '0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_wr(input int p, input reg_addr_t a, input xlen_t d);
      we[p] = 1'b1;
      wa[p*AW +: AW] = a;
      wd[p*XL +: XL] = d;
   endtask

   task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
      rs_addr = {a1, a0};
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); set_rd(5'd4, 5'd0);
      #2;
      tests_run++; if (rs_data !== 64'd0) begin fails++; $display("FAIL reset_data got %0h exp 0", rs_data); end
      tests_run++; if (rs_ready !== 2'b11) begin fails++; $display("FAIL reset_ready got %b exp 11", rs_ready); end
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL reset_iss_ok got %b exp 1", iss_ok); end
      tests_run++; if (rs_data_nb !== 64'd0) begin fails++; $display("FAIL reset_data_nb got %0h exp 0", rs_data_nb); end
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_write_read();
      idle(); set_wr(0, 5'd4, 32'd42);
      step();
      idle(); set_rd(5'd4, 5'd0); #1;
      tests_run++; if (rs_data[31:0] !== 32'd42) begin fails++; $display("FAIL wr_rd_data0 got %0d exp 42", rs_data[31:0]); end
      tests_run++; if (rs_data[63:32] !== 32'd0) begin fails++; $display("FAIL wr_rd_data1 got %0d exp 0", rs_data[63:32]); end
      tests_run++; if (rs_ready !== 2'b11) begin fails++; $display("FAIL wr_rd_ready got %b exp 11", rs_ready); end
   endtask

   task automatic test_same_addr();
      idle(); set_wr(0, 5'd5, 32'd7); set_wr(1, 5'd5, 32'd9);
      step();
      idle(); set_rd(5'd5, 5'd0); #1;
      tests_run++; if (rs_data[31:0] !== 32'd9) begin fails++; $display("FAIL same_addr got %0d exp 9", rs_data[31:0]); end
      tests_run++; if (rs_data_nb[31:0] !== 32'd9) begin fails++; $display("FAIL same_addr_nb got %0d exp 9", rs_data_nb[31:0]); end
   endtask

   task automatic test_bypass();
      idle(); set_wr(0, 5'd2, 32'd99); set_rd(5'd2, 5'd0); #1;
      tests_run++; if (rs_data[31:0] !== 32'd99) begin fails++; $display("FAIL bypass_data got %0d exp 99", rs_data[31:0]); end
      tests_run++; if (rs_ready[0] !== 1'b1) begin fails++; $display("FAIL bypass_ready got %b exp 1", rs_ready[0]); end
      tests_run++; if (rs_data_nb[31:0] !== 32'd0) begin fails++; $display("FAIL nobypass_before got %0d exp 0", rs_data_nb[31:0]); end
      step();
      idle(); #1;
      tests_run++; if (rs_data_nb[31:0] !== 32'd99) begin fails++; $display("FAIL nobypass_after got %0d exp 99", rs_data_nb[31:0]); end
   endtask

   task automatic test_scoreboard();
      idle(); iss_valid = 1'b1; iss_rd = 5'd6; #1;
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL sb_iss_ok_free got %b exp 1", iss_ok); end
      step();
      idle(); iss_rd = 5'd6; set_rd(5'd6, 5'd0); #1;
      tests_run++; if (iss_ok !== 1'b0) begin fails++; $display("FAIL sb_iss_ok_busy got %b exp 0", iss_ok); end
      tests_run++; if (rs_ready[0] !== 1'b0) begin fails++; $display("FAIL sb_ready_busy got %b exp 0", rs_ready[0]); end
      set_wr(0, 5'd6, 32'd123);
      step();
      idle(); iss_rd = 5'd6; #1;
      tests_run++; if (rs_ready[0] !== 1'b1) begin fails++; $display("FAIL sb_ready_done got %b exp 1", rs_ready[0]); end
      tests_run++; if (rs_data[31:0] !== 32'd123) begin fails++; $display("FAIL sb_data_done got %0d exp 123", rs_data[31:0]); end
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL sb_iss_ok_done got %b exp 1", iss_ok); end
   endtask

   task automatic test_issue_write_flush();
      idle(); iss_valid = 1'b1; iss_rd = 5'd7; set_wr(1, 5'd7, 32'd5);
      step();
      idle(); iss_rd = 5'd7; set_rd(5'd7, 5'd0); #1;
      tests_run++; if (rs_data[31:0] !== 32'd5) begin fails++; $display("FAIL iw_data got %0d exp 5", rs_data[31:0]); end
      tests_run++; if (rs_ready[0] !== 1'b0) begin fails++; $display("FAIL iw_ready got %b exp 0", rs_ready[0]); end
      tests_run++; if (iss_ok !== 1'b0) begin fails++; $display("FAIL iw_iss_ok got %b exp 0", iss_ok); end
      flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd8;
      step();
      idle(); iss_rd = 5'd8; #1;
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL flush_r8_ok got %b exp 1", iss_ok); end
      tests_run++; if (rs_ready[0] !== 1'b1) begin fails++; $display("FAIL flush_r7_ready got %b exp 1", rs_ready[0]); end
      iss_rd = 5'd7; #1;
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL flush_r7_ok got %b exp 1", iss_ok); end
   endtask

   task automatic test_reg0();
      idle(); set_wr(0, 5'd0, 32'hDEADBEEF); iss_valid = 1'b1; iss_rd = 5'd0; set_rd(5'd0, 5'd0); #1;
      tests_run++; if (rs_data !== 64'd0) begin fails++; $display("FAIL r0_same_cycle got %0h exp 0", rs_data); end
      tests_run++; if (rs_ready !== 2'b11) begin fails++; $display("FAIL r0_same_ready got %b exp 11", rs_ready); end
      step();
      idle(); iss_rd = 5'd0; #1;
      tests_run++; if (rs_data[31:0] !== 32'd0) begin fails++; $display("FAIL r0_after got %0h exp 0", rs_data[31:0]); end
      tests_run++; if (rs_data_nb[31:0] !== 32'd0) begin fails++; $display("FAIL r0_after_nb got %0h exp 0", rs_data_nb[31:0]); end
      tests_run++; if (rs_ready !== 2'b11) begin fails++; $display("FAIL r0_ready got %b exp 11", rs_ready); end
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL r0_iss_ok got %b exp 1", iss_ok); end
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 31; i += 2) begin
         idle();
         set_wr(0, reg_addr_t'(i), xlen_t'(i*3 + 1));
         if (i < 31) set_wr(1, reg_addr_t'(i + 1), xlen_t'((i + 1)*3 + 1));
         step();
      end
      idle(); iss_valid = 1'b1; iss_rd = 5'd9;
      step();
      idle(); iss_rd = 5'd9; set_rd(5'd31, 5'd17); #1;
      tests_run++; if (rs_data[31:0] !== 32'd94) begin fails++; $display("FAIL fill_r31 got %0d exp 94", rs_data[31:0]); end
      tests_run++; if (rs_data[63:32] !== 32'd52) begin fails++; $display("FAIL fill_r17 got %0d exp 52", rs_data[63:32]); end
      tests_run++; if (iss_ok !== 1'b0) begin fails++; $display("FAIL fill_r9_busy got %b exp 0", iss_ok); end
      #1 rst = 1'b1; #1;
      tests_run++; if (rs_data !== 64'd0) begin fails++; $display("FAIL arst_data got %0h exp 0", rs_data); end
      tests_run++; if (rs_data_nb !== 64'd0) begin fails++; $display("FAIL arst_data_nb got %0h exp 0", rs_data_nb); end
      tests_run++; if (rs_ready !== 2'b11) begin fails++; $display("FAIL arst_ready got %b exp 11", rs_ready); end
      tests_run++; if (iss_ok !== 1'b1) begin fails++; $display("FAIL arst_iss_ok got %b exp 1", iss_ok); end
      set_wr(0, 5'd3, 32'd5); set_rd(5'd3, 5'd0); #1;
      tests_run++; if (rs_data[31:0] !== 32'd0) begin fails++; $display("FAIL arst_no_bypass got %0d exp 0", rs_data[31:0]); end
      step();
      idle(); rst = 1'b0; #1;
      tests_run++; if (rs_data[31:0] !== 32'd0) begin fails++; $display("FAIL arst_write_dropped got %0d exp 0", rs_data[31:0]); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_same_addr();
      test_bypass();
      test_scoreboard();
      test_issue_write_flush();
      test_reg0();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/rf_sb.md
Name: rf_sb

Overview:
- Parametrised multi-port integer register file: XLEN-bit registers, NUM_RD combinational read ports, NUM_WR synchronous write ports.
- Optional write-to-read bypass, selected by a parameter.
- Integrated per-register scoreboard (busy bits) so the decode stage can detect and stall on pending multi-cycle writebacks.
- Replaces the single-write, dual-read rf in the core datapath between decode (reads, issue) and writeback (writes).

Parameters:
- XLEN, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the array only.
- AW, $clog2(NUM_REGS), address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW].
- rs_data  out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rs_ready  out  NUM_RD  1 = port i value is architecturally final (register not busy, or bypassed).
- we  in  NUM_WR  write enables.
- wa  in  NUM_WR*AW  write addresses.
- wd  in  NUM_WR*XLEN  write data.
- iss_valid  in  1  decode requests to mark iss_rd pending.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_ok  out  1  = !busy[iss_rd]; combinational.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).

Behaviour:
- Reset, asynchronous: all registers = 0 and all busy bits = 0, effective immediately.
  - Outputs during reset follow from the cleared state: rs_data = 0, rs_ready = all 1s, iss_ok = 1.
  - Reset asserted mid-operation discards any in-flight write or issue in that cycle.
- Register 0 is hardwired to 0.
  - Writes to address 0 are ignored. Issue to address 0 is ignored. busy[0] is always 0.
  - Reads of address 0 return 0 with ready = 1, regardless of bypass.
- Write: on a rising edge with we[j]=1 and wa[j]!=0, reg[wa[j]] <= wd[j], and busy[wa[j]] is cleared.
  - Write latency: 1 cycle to the array.
  - When two or more ports hit the same address in one cycle, the highest-index port wins for data.
- Read: combinational, zero-latency.
  - BYPASS=1: if any enabled write port targets rs_addr[i] (non-zero) this cycle, rs_data[i] = wd of the highest-index matching port and rs_ready[i] = 1.
  - Otherwise rs_data[i] = reg[rs_addr[i]] and rs_ready[i] = !busy[rs_addr[i]].
  - BYPASS=0: array value and busy bit only; no forwarding.
- Issue: iss_valid && iss_ok && iss_rd!=0 sets busy[iss_rd] at the edge.
  - iss_valid with iss_ok=0 has no effect; the caller must stall and hold the request.
  - Issue and write to the same register in the same cycle: busy ends set (new producer wins); the array is still written.
- flush: clears every busy bit at the edge and overrides any issue in the same cycle. Writes in the same cycle still update the array.
- Priority of next busy bit per register: rst > flush > issue > write-clear > hold.
- Out-of-range addresses cannot occur (NUM_REGS is a power of two).

Decomposition:
- Package rf_pkg holds: default XLEN and NUM_REGS as localparams, and typedefs reg_addr_t (logic [AW-1:0]) and xlen_t (logic [XLEN-1:0]).
- One sub-module, rf_scoreboard, owns the busy vector, issue/write-clear/flush logic and iss_ok.
- Data array, write-port priority and bypass muxing stay in rf_sb.

Test Plan:
- Reset, then write 42 to reg 4 via port 0; next cycle read rs0=4, rs1=0 -> rs_data 42 and 0, rs_ready 2'b11.
- Same cycle: port0 writes 7 and port1 writes 9 to reg 5; next cycle read reg 5 -> 9.
- BYPASS=1: write 99 to reg 2 and read rs0=2 in the same cycle -> rs_data0 = 99, ready 1 before the edge. With BYPASS=0 the same stimulus gives the old value 0 before the edge and 99 after.
- Issue reg 6 -> busy; iss_ok=0 for iss_rd=6; reading reg 6 gives ready=0. Write 123 to reg 6 -> next cycle ready=1, data 123, iss_ok=1.
- Issue reg 7 while port1 writes 5 to reg 7 in the same cycle -> reg 7 = 5, busy[7] = 1. Then assert flush together with issue to reg 8 -> all busy 0, reg 8 not busy.
- Write 0xDEADBEEF to reg 0 and issue reg 0 -> reads 0, ready 1, iss_ok 1. Assert rst mid-run after filling regs 1..31 -> all reads 0 immediately, asynchronously, without a clock edge.
